// File: rtl/countdown_timer_pkg.sv
// Shared types and default widths for the countdown timer slice.
package countdown_timer_pkg;
  localparam int COUNT_W_DEFAULT    = 16;
  localparam int PRESCALE_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } timer_state_e;
endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Prescaler for the countdown timer: emits one tick every (latched prescale + 1) enabled cycles.
module tick_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PRESCALE_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic                      i_latch,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tick
);
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_lat;
  logic                      w_tick;

  assign w_tick = i_enable && (r_cnt == r_lat);
  assign o_tick = w_tick;

  // Latching a new prescale always restarts the count from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_lat <= '0;
    end else if (i_latch) begin
      r_lat <= i_prescale;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with a one-cycle expired pulse at terminal count.
// Optional auto-reload at terminal count: define COUNTDOWN_TIMER_AUTO_RELOAD_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int COUNT_WIDTH    = COUNT_W_DEFAULT,
  parameter int PRESCALE_WIDTH = PRESCALE_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic [COUNT_WIDTH-1:0]    i_load_value,
  input  logic                      i_start,
  input  logic                      i_pause,
  input  logic                      i_abort,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic [COUNT_WIDTH-1:0]    o_count,
  output logic                      o_busy,
  output logic                      o_paused,
  output logic                      o_expired
);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  timer_state_e           r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_reload;
  logic                   r_expired;
  logic                   w_tick;
  logic                   w_enable;
  logic                   w_latch;
  logic                   w_clear;

  // A pausing, aborting or loading edge must not advance the prescaler.
  assign w_enable = (r_state == RUN) && !i_load && !i_abort && !i_pause;
  assign w_latch  = (r_state == IDLE) && !i_load && !i_abort && !i_pause &&
                    i_start && (r_count != '0);
  assign w_clear  = i_load || i_abort;

  tick_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_latch    (w_latch),
    .i_prescale (i_prescale),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (i_load) begin
        r_count  <= i_load_value;
        r_reload <= i_load_value;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!i_abort && !i_pause && i_start) begin
              if (r_count != '0) r_state <= RUN;
              else               r_expired <= 1'b1;
            end
          end
          RUN: begin
            if (i_abort) begin
              r_state <= IDLE;
            end else if (i_pause) begin
              r_state <= PAUSE;
            end else if (w_tick) begin
              if (r_count <= COUNT_WIDTH'(1)) begin
                r_expired <= 1'b1;
                if (AUTO_RELOAD && (r_reload != '0)) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_state <= IDLE;
                end
              end else begin
                r_count <= r_count - 1'b1;
              end
            end
          end
          PAUSE: begin
            if (i_abort)       r_state <= IDLE;
            else if (!i_pause) r_state <= RUN;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_count   = r_count;
  assign o_expired = r_expired;
  assign o_busy    = (r_state == RUN) || (r_state == PAUSE);
  assign o_paused  = (r_state == PAUSE);
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable, prescaled down-counter that complements the team's loadable up-counter. It is used wherever a block must wait a programmed number of ticks and then be told the interval is over.
- Software or control logic loads an interval, starts it, and may pause or abort it.
- The block decrements toward zero and emits a one-cycle expired pulse at terminal count.
- It sits beside control FSMs as a timeout/interval source.

Parameters:
COUNT_WIDTH, 16, width of count, load_value and the reload register
PRESCALE_WIDTH, 8, width of prescale and the internal prescaler counter

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  write load_value into count and reload register
load_value  input  COUNT_WIDTH  interval value
start  input  1  begin counting from current count
pause  input  1  level; freezes counting while high in RUN
abort  input  1  stop counting; count holds its current value
prescale  input  PRESCALE_WIDTH  count decrements once every prescale+1 cycles
count  output  COUNT_WIDTH  current remaining count (registered)
busy  output  1  high in RUN or PAUSE
paused  output  1  high in PAUSE
expired  output  1  one-cycle pulse at terminal count (registered)

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset: state IDLE; count 0, reload register 0, latched prescale 0, prescaler 0, expired 0.
- Input priority per edge: reset > load > abort > pause > start.
- States, from countdown_timer_pkg:
  - IDLE:
    - load: count <= load_value, reload <= load_value.
    - start with count != 0: latch prescale, clear prescaler, go RUN.
    - start with count == 0: expired <= 1, stay IDLE.
  - RUN:
    - Tick when prescaler == latched prescale: prescaler <= 0 and count <= count-1. Otherwise prescaler <= prescaler+1.
    - Tick with count == 1: count <= 0, expired <= 1, go IDLE.
    - pause high: go PAUSE; count and prescaler frozen, and that edge produces no tick.
  - PAUSE: counting frozen. pause low: return to RUN and resume the prescaler where it stopped.
- abort in RUN/PAUSE: go IDLE; count holds; prescaler cleared; no expired pulse.
- load in RUN/PAUSE: count and reload <= load_value; go IDLE; prescaler cleared; no expired pulse. A simultaneous start is ignored.
- start while RUN/PAUSE: ignored.
- Latency, with start sampled at edge E0:
  - First decrement at edge E0+(P+1), where P is the latched prescale.
  - expired is asserted after edge E0+L*(P+1), in the same cycle count first reads 0.
- Prescale changes mid-run have no effect until the next start.
- expired is high for exactly one cycle; it is cleared on every edge where it is not set.
- count never underflows: no decrement occurs at 0.

Optional Feature:
Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- Defined: at terminal tick, count <= reload register, state stays RUN, prescaler cleared, expired still pulses. Count never reads 0 in this case. If reload is 0, behave as undefined-macro (go IDLE, count 0).
- Undefined: at terminal tick, go IDLE with count 0; the reload register is still written by load but otherwise unused.

Decomposition:
- Package countdown_timer_pkg holds:
  - state enum typedef timer_state_e {IDLE, RUN, PAUSE}, 2 bits.
  - default width localparams COUNT_W_DEFAULT=16 and PRESCALE_W_DEFAULT=8.
- Sub-module tick_prescaler:
  - Holds the PRESCALE_WIDTH counter plus the latched prescale.
  - Inputs: clear, enable, latch.
  - Output: single-cycle tick.
  - countdown_timer instantiates it once.

Test Plan:
- Load 5, prescale 0, start -> count reads 4,3,2,1,0 on the 5 following cycles; expired high only in the count=0 cycle; busy low afterwards.
- Load 3, prescale 2, start -> decrements every 3 cycles; expired asserted exactly 9 cycles after the start edge.
- Load 10, prescale 0, start; hold pause 4 cycles when count=7 -> count stays 7 and paused=1; after release, 6 appears one cycle later.
- Start with count 0 -> expired pulses once the next cycle; busy never asserts.
- Load 20 while RUN at count 5 -> count=20, IDLE, no expired. Also: abort at count 5 -> count holds 5, IDLE. Also: reset mid-run -> all outputs 0 next cycle.
- With COUNTDOWN_TIMER_AUTO_RELOAD_EN: load 2, prescale 0, start -> count 1,2,1,2...; expired every 2 cycles; busy stays high until abort.
